// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   idx_width : width of the bit-index counter for a given operand width
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // clog2-based counter width, never narrower than one bit.
  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Single-bit full adder cell (purely combinational).
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module bit_serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder controller: {co,s} = a + b + ci, one bit per cycle, LSB
// first, through a single full-adder cell.
//   clk, rst_n     : clock, synchronous active-low reset
//   a, b, ci       : operands and carry-in, sampled only when accepted
//   in_vld, in_rd  : operand handshake (in_rd high only in IDLE)
//   s, co, ovf     : registered result (held at last value outside DONE)
//   out_vld, out_rd: result handshake (out_vld high only in DONE)
//   busy           : high in RUN or DONE
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  ci,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] s,
  output logic                  co,
  output logic                  ovf,
  output logic                  out_vld,
  input  logic                  out_rd,
  output logic                  busy
);

  localparam int              IDX_W    = idx_width(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   a_sh_reg, b_sh_reg, sum_sh_reg;
  logic                    carry_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [DATA_WIDTH-1:0]   s_reg;
  logic                    co_reg, ovf_reg;
  logic                    in_rd_reg;
  logic                    fa_s, fa_co;
  logic                    accept, last_bit;

  bit_serial_adder_fa u_fa (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept   = (state_reg == IDLE) && in_rd_reg && in_vld;
  assign last_bit = (state_reg == RUN) && (idx_reg == IDX_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_vld && in_rd_reg) state_next = RUN;
      RUN:     if (idx_reg == IDX_LAST) state_next = DONE;
      DONE:    if (out_rd) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      in_rd_reg  <= 1'b0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      carry_reg  <= 1'b0;
      idx_reg    <= '0;
      s_reg      <= '0;
      co_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Registered ready: low throughout reset, high the cycle after the
      // first edge that sees rst_n high, and whenever IDLE is entered.
      in_rd_reg <= (state_next == IDLE);

      if (accept) begin
        a_sh_reg  <= a;
        b_sh_reg  <= b;
        carry_reg <= ci;
        idx_reg   <= '0;
      end else if (state_reg == RUN) begin
        a_sh_reg   <= a_sh_reg >> 1;
        b_sh_reg   <= b_sh_reg >> 1;
        sum_sh_reg <= {fa_s, sum_sh_reg[DATA_WIDTH-1:1]};
        carry_reg  <= fa_co;
        idx_reg    <= idx_reg + 1'b1;
      end

      // Result registers update only on the MSB step, so they hold their
      // last value through IDLE and RUN. carry_reg is still the carry into
      // the MSB here, which is what signed overflow compares against.
      if (last_bit) begin
        s_reg   <= {fa_s, sum_sh_reg[DATA_WIDTH-1:1]};
        co_reg  <= fa_co;
        ovf_reg <= carry_reg ^ fa_co;
      end
    end
  end

  assign in_rd   = in_rd_reg;
  assign s       = s_reg;
  assign co      = co_reg;
  assign ovf     = ovf_reg;
  assign out_vld = (state_reg == DONE);
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  localparam int DW = 4;

  logic          clk, rst_n, ci, in_vld, out_rd;
  logic [DW-1:0] a, b;
  logic          in_rd, co, ovf, out_vld, busy;
  logic [DW-1:0] s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit_serial_adder #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .in_vld  (in_vld),
    .in_rd   (in_rd),
    .s       (s),
    .co      (co),
    .ovf     (ovf),
    .out_vld (out_vld),
    .out_rd  (out_rd),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ci;
    logic [DW-1:0] s;
    logic          co;
    logic          ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for acceptance, then check latency and result.
  // Leaves the DUT in IDLE if out_rd is high, otherwise parked in DONE.
  task automatic run_op(input string name, input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                        input logic tci, input logic [DW-1:0] es, input logic ec, input logic eo);
    int n;
    a = ta; b = tb_v; ci = tci; in_vld = 1'b1;
    n = 0;
    while (in_rd !== 1'b1 && n < 20) begin tick(); n++; end
    check({name, "_in_rd_before"}, 64'(in_rd), 64'(1'b1));
    tick();                       // accept edge
    in_vld = 1'b0;
    a = ~ta; b = ~tb_v; ci = ~tci; // must not affect the running add
    n = 0;
    while (out_vld !== 1'b1 && n < 20) begin tick(); n++; end
    check({name, "_out_vld"}, 64'(out_vld), 64'(1'b1));
    check({name, "_latency"}, 64'(n), 64'(4));
    check({name, "_s"}, 64'(s), 64'(es));
    check({name, "_co"}, 64'(co), 64'(ec));
    check({name, "_ovf"}, 64'(ovf), 64'(eo));
    check({name, "_in_rd_done"}, 64'(in_rd), 64'(1'b0));
    check({name, "_busy_done"}, 64'(busy), 64'(1'b1));
    $display("op %s: %0d+%0d+%0d -> s=%0d co=%0d ovf=%0d lat=%0d", name, ta, tb_v, tci, s, co, ovf, n);
    if (out_rd) begin
      tick();
      check({name, "_out_vld_after"}, 64'(out_vld), 64'(1'b0));
      check({name, "_in_rd_after"}, 64'(in_rd), 64'(1'b1));
    end
  endtask

  initial begin
    int n, acc, prev;
    bit seen;
    logic [DW-1:0] ra, rb, es;
    logic rc, ec, eo;
    logic [DW:0] sum5;
    logic [DW-1:0] low;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  ci: 1'b0, s: 4'd8,  co: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 4'd15, b: 4'd1,  ci: 1'b0, s: 4'd0,  co: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 4'd7,  b: 4'd0,  ci: 1'b1, s: 4'd8,  co: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 4'd8,  b: 4'd8,  ci: 1'b1, s: 4'd1,  co: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 4'd0,  b: 4'd0,  ci: 1'b0, s: 4'd0,  co: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 4'd9,  b: 4'd14, ci: 1'b1, s: 4'd8,  co: 1'b1, ovf: 1'b0};

    rst_n = 1'b0; in_vld = 1'b0; out_rd = 1'b1; a = '0; b = '0; ci = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_in_rd", 64'(in_rd), 64'(1'b0));
    check("rst_out_vld", 64'(out_vld), 64'(1'b0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_s", 64'(s), 64'(0));
    check("rst_co", 64'(co), 64'(1'b0));
    check("rst_ovf", 64'(ovf), 64'(1'b0));
    rst_n = 1'b1;
    tick();
    check("rst_release_in_rd", 64'(in_rd), 64'(1'b1));

    // Directed table
    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, vecs[i].ovf);

    // Back-pressure in DONE with an ignored in_vld pulse
    out_rd = 1'b0;
    run_op("bp", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin a = 4'd1; b = 4'd1; ci = 1'b0; in_vld = 1'b1; end
      else in_vld = 1'b0;
      tick();
      check($sformatf("bp_hold%0d_out_vld", k), 64'(out_vld), 64'(1'b1));
      check($sformatf("bp_hold%0d_s", k), 64'(s), 64'(8));
      check($sformatf("bp_hold%0d_co", k), 64'(co), 64'(1'b0));
      check($sformatf("bp_hold%0d_ovf", k), 64'(ovf), 64'(1'b1));
      check($sformatf("bp_hold%0d_in_rd", k), 64'(in_rd), 64'(1'b0));
    end
    in_vld = 1'b0;
    out_rd = 1'b1;
    tick();
    check("bp_release_out_vld", 64'(out_vld), 64'(1'b0));
    check("bp_release_in_rd", 64'(in_rd), 64'(1'b1));
    check("bp_release_busy", 64'(busy), 64'(1'b0));
    $display("op bp: held 5 cycles, released to IDLE");

    // Reset in the middle of RUN
    a = 4'd5; b = 4'd5; ci = 1'b0; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick(); tick();
    check("midrst_busy_run", 64'(busy), 64'(1'b1));
    rst_n = 1'b0;
    tick();
    check("midrst_in_rd_low", 64'(in_rd), 64'(1'b0));
    check("midrst_busy", 64'(busy), 64'(1'b0));
    check("midrst_s", 64'(s), 64'(0));
    rst_n = 1'b1;
    tick();
    check("midrst_in_rd_release", 64'(in_rd), 64'(1'b1));
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_vld === 1'b1) seen = 1'b1;
      tick();
    end
    check("midrst_no_out_vld", 64'(seen), 64'(1'b0));
    $display("op midrst: aborted 5+5, out_vld_seen=%0d", seen);
    run_op("after_rst", 4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0);

    // Back-to-back random operations
    in_vld = 1'b1;
    out_rd = 1'b1;
    prev = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; ci = rc;
      n = 0;
      while (in_rd !== 1'b1 && n < 20) begin tick(); n++; end
      tick();
      acc = cyc;
      if (i > 0) check($sformatf("rnd%0d_spacing", i), 64'(acc - prev), 64'(6));
      prev = acc;
      n = 0;
      while (out_vld !== 1'b1 && n < 20) begin tick(); n++; end
      sum5 = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
      low  = {1'b0, ra[2:0]} + {1'b0, rb[2:0]} + {3'b0, rc};
      es = sum5[DW-1:0];
      ec = sum5[DW];
      eo = low[DW-1] ^ sum5[DW];
      check($sformatf("rnd%0d_out_vld", i), 64'(out_vld), 64'(1'b1));
      check($sformatf("rnd%0d_s", i), 64'(s), 64'(es));
      check($sformatf("rnd%0d_co", i), 64'(co), 64'(ec));
      check($sformatf("rnd%0d_ovf", i), 64'(ovf), 64'(eo));
      $display("op rnd%0d: %0d+%0d+%0d -> s=%0d co=%0d ovf=%0d", i, ra, rb, rc, s, co, ovf);
    end
    in_vld = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
